// File: rtl/seq_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W = 4;

endpackage

// File: rtl/seq_sub_if.sv
// Request/result bundle of seq_sub: operands in, handshake and result out.
interface seq_sub_if
    import seq_sub_pkg::*;
#(
    parameter int W = DEF_W
) ();

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;

    modport master (output start, a, b, bi, input busy, done, d, bo);
    modport slave  (input start, a, b, bi, output busy, done, d, bo);

endinterface

// File: rtl/seq_sub_fs_bit.sv
// One-bit full subtractor from primitive gates: D = X ^ Y ^ Bi, Bo = ~X&Y | ~(X^Y)&Bi.
module fs_bit (
    output wire Bo,
    output wire D,
    input  wire X,
    input  wire Y,
    input  wire Bi
);

    wire xy_s;
    wire nx_s;
    wire nxy_s;
    wire gen_s;
    wire prop_s;

    xor u_x1 (xy_s, X, Y);
    xor u_x2 (D, xy_s, Bi);
    not u_n1 (nx_s, X);
    not u_n2 (nxy_s, xy_s);
    and u_a1 (gen_s, nx_s, Y);
    and u_a2 (prop_s, nxy_s, Bi);
    or  u_o1 (Bo, gen_s, prop_s);

endmodule

// File: rtl/seq_sub.sv
// Bit-serial W-bit subtractor: one fs_bit cell walks the operands LSB first,
// framed by a start/busy/done handshake.
module seq_sub
    import seq_sub_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_sub_if.slave bus
);

    localparam int          CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    state_t        state_r;
    state_t        state_s;
    logic          accept_s;
    logic          last_s;
    logic [W-1:0]  a_sh_r;
    logic [W-1:0]  b_sh_r;
    logic [W-1:0]  res_r;
    logic [W-1:0]  d_r;
    logic          borrow_r;
    logic          bo_r;
    logic          busy_r;
    logic          done_r;
    logic [CW-1:0] cnt_r;
    wire           diff_s;
    wire           borrow_s;

    fs_bit u_fs_bit (
        .Bo (borrow_s),
        .D  (diff_s),
        .X  (a_sh_r[0]),
        .Y  (b_sh_r[0]),
        .Bi (borrow_r)
    );

    // Next-state decode; accept_s marks an edge that captures new operands.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = DONE;
                    last_s  = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand capture, per-bit shifting and the all-at-once result update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r   <= {W{1'b0}};
            b_sh_r   <= {W{1'b0}};
            res_r    <= {W{1'b0}};
            d_r      <= {W{1'b0}};
            borrow_r <= 1'b0;
            bo_r     <= 1'b0;
            cnt_r    <= CNT_ZERO;
        end else if (accept_s) begin
            a_sh_r   <= bus.a;
            b_sh_r   <= bus.b;
            borrow_r <= bus.bi;
            res_r    <= {W{1'b0}};
            cnt_r    <= CNT_LAST;
        end else if (state_r == RUN) begin
            a_sh_r   <= {1'b0, a_sh_r[W-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[W-1:1]};
            borrow_r <= borrow_s;
            res_r    <= {diff_s, res_r[W-1:1]};
            if (last_s) begin
                // d is published whole so it never shows a half-built value
                d_r  <= {diff_s, res_r[W-1:1]};
                bo_r <= borrow_s;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.d    = d_r;
    assign bus.bo   = bo_r;

endmodule
